// File: rtl/genesis_pad_emulator.sv
// Device side of the Genesis DB-9 pad protocol: follows the console select line
// through the 3/6-button phase sequence and drives the six active-low data pins.
module genesis_pad_emulator #(
   parameter bit SIX_BUTTON     = 1'b1,
   parameter int TIMEOUT_CYCLES = 75000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] buttons,
   input  logic        select_in,
   output logic        pad_up_z,
   output logic        pad_down_y,
   output logic        pad_left_x,
   output logic        pad_right_mode,
   output logic        pad_a_b,
   output logic        pad_start_c,
   output logic [2:0]  phase
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   sel, sel_d, evt, expire;
   logic [2:0]             p, p_next;
   logic [TW-1:0]          tcnt;
   logic [11:0]            snap, src;
   logic [5:0]             pins, pins_next;

   assign sel    = sync[SYNC_STAGES-1];
   assign evt    = sel ^ sel_d;
   assign expire = (tcnt == T_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '1;
         sel_d <= 1'b1;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], select_in};
         sel_d <= sel;
      end
   end

   // A select edge outranks a timeout landing in the same cycle.
   always_comb begin
      p_next = p;
      if (evt) begin
         if (SIX_BUTTON) p_next = p + 3'd1;
         else            p_next = sel ? 3'd0 : 3'd1;
      end else if (expire) begin
         p_next = sel ? 3'd0 : 3'd1;
      end
   end

   // Phases beyond 1 read the snapshot so a full 6-button read is coherent.
   always_comb begin
      src       = (p_next <= 3'd1) ? buttons : snap;
      pins_next = 6'h3F;
      case (p_next)
         3'd0, 3'd2, 3'd4: pins_next = ~{src[0], src[1], src[2], src[3], src[5], src[6]};
         3'd1, 3'd3:       pins_next = {~src[0], ~src[1], 2'b00, ~src[4], ~src[7]};
         3'd5:             pins_next = {4'b0000, ~src[4], ~src[7]};
         3'd6:             pins_next = ~{src[10], src[9], src[8], src[11], src[5], src[6]};
         default:          pins_next = {4'b1111, ~src[4], ~src[7]};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p    <= 3'd0;
         tcnt <= '0;
         snap <= '0;
         pins <= 6'h3F;
      end else begin
         p    <= p_next;
         tcnt <= (evt || expire) ? '0 : tcnt + TW'(1);
         if (evt && p == 3'd0 && p_next == 3'd1)
            snap <= buttons;
         pins <= pins_next;
      end
   end

   assign {pad_up_z, pad_down_y, pad_left_x, pad_right_mode, pad_a_b, pad_start_c} = pins;
   assign phase = p;

endmodule

// File: tb/tb_genesis_pad_emulator.sv
// Directed bench for genesis_pad_emulator: a 6-button instance and a 3-button
// instance share stimulus; pins are packed as {pin1,pin2,pin3,pin4,pin6,pin9}.
module tb_genesis_pad_emulator;

   localparam int T = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] buttons = 12'hFFF;
   logic        select_in = 1'b1;

   logic       u6, d6, l6, r6, a6, s6;
   logic       u3, d3, l3, r3, a3, s3;
   logic [2:0] phase6, phase3;
   wire  [5:0] pins6 = {u6, d6, l6, r6, a6, s6};
   wire  [5:0] pins3 = {u3, d3, l3, r3, a3, s3};

   int checks = 0;
   int errors = 0;

   genesis_pad_emulator #(.SIX_BUTTON(1'b1), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .buttons(buttons), .select_in(select_in),
      .pad_up_z(u6), .pad_down_y(d6), .pad_left_x(l6), .pad_right_mode(r6),
      .pad_a_b(a6), .pad_start_c(s6), .phase(phase6));

   genesis_pad_emulator #(.SIX_BUTTON(1'b0), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut3 (
      .clk(clk), .reset(reset), .buttons(buttons), .select_in(select_in),
      .pad_up_z(u3), .pad_down_y(d3), .pad_left_x(l3), .pad_right_mode(r3),
      .pad_a_b(a3), .pad_start_c(s3), .phase(phase3));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic toggle();
      select_in = ~select_in;
   endtask

   logic [5:0] cyc_pins [1:7];

   initial begin
      cyc_pins[1] = 6'b110011; cyc_pins[2] = 6'b111110; cyc_pins[3] = 6'b110011;
      cyc_pins[4] = 6'b111110; cyc_pins[5] = 6'b000011; cyc_pins[6] = 6'b011010;
      cyc_pins[7] = 6'b111111;

      // reset state
      tick(3);
      chk("reset_pins", 32'(pins6), 32'h3F);
      chk("reset_phase", 32'(phase6), 32'd0);
      reset = 1'b0;
      tick(1);
      chk("post_reset_pins", 32'(pins6), 32'h00);

      // Up|A, select falls: latency boundary then phase 1 mapping
      buttons = 12'h011;
      toggle();
      tick(2);
      chk("pre_latency_phase", 32'(phase6), 32'd0);
      chk("p0_live_pins", 32'(pins6), 32'b011111);
      tick(1);
      chk("p1_phase", 32'(phase6), 32'd1);
      chk("p1_pins", 32'(pins6), 32'b010001);
      buttons = 12'h000;
      tick(1);
      chk("btn_latency", 32'(pins6), 32'b110011);

      // full 6-button cycle with Z|Mode|C
      reset = 1'b1;
      select_in = 1'b1;
      buttons = 12'hC40;
      tick(2);
      reset = 1'b0;
      tick(1);
      for (int k = 1; k <= 7; k++) begin
         toggle();
         tick(20);
         chk($sformatf("cyc_phase%0d", k), 32'(phase6), 32'(k));
         chk($sformatf("cyc_pins%0d", k), 32'(pins6), 32'(cyc_pins[k]));
      end
      toggle();
      tick(20);
      chk("wrap_phase", 32'(phase6), 32'd0);
      chk("wrap_pins", 32'(pins6), 32'b111110);

      // snapshot coherency: X pressed after the 0->1 edge is not seen at p=6
      buttons = 12'h000;
      toggle();
      tick(20);
      buttons = 12'h100;
      tick(1);
      chk("snap_p1_pins", 32'(pins6), 32'b110011);
      for (int k = 0; k < 5; k++) begin
         toggle();
         tick(20);
      end
      chk("snap_p6_phase", 32'(phase6), 32'd6);
      chk("snap_p6_pins", 32'(pins6), 32'b111111);

      // timeout at p=3, select low
      for (int k = 0; k < 5; k++) begin
         toggle();
         tick(20);
      end
      chk("to_low_start", 32'(phase6), 32'd3);
      tick(T - 18);
      chk("to_low_before", 32'(phase6), 32'd3);
      tick(1);
      chk("to_low_restart", 32'(phase6), 32'd1);
      chk("to_low_pins", 32'(pins6), 32'b110011);

      // timeout with select high
      toggle();
      tick(3);
      chk("to_high_start", 32'(phase6), 32'd2);
      tick(T - 1);
      chk("to_high_before", 32'(phase6), 32'd2);
      tick(1);
      chk("to_high_restart", 32'(phase6), 32'd0);

      // select edge landing on the expiry cycle wins
      tick(20);
      for (int k = 0; k < 3; k++) begin
         toggle();
         tick(20);
      end
      chk("race_start", 32'(phase6), 32'd3);
      tick(T - 20);
      toggle();
      tick(3);
      chk("race_phase", 32'(phase6), 32'd4);
      tick(5);
      chk("race_hold", 32'(phase6), 32'd4);

      // 3-button instance: phase follows select, no ID pattern
      reset = 1'b1;
      select_in = 1'b1;
      buttons = 12'h000;
      tick(2);
      reset = 1'b0;
      tick(1);
      chk("b3_reset_phase", 32'(phase3), 32'd0);
      for (int k = 1; k <= 10; k++) begin
         toggle();
         tick(20);
         chk($sformatf("b3_phase%0d", k), 32'(phase3), select_in ? 32'd0 : 32'd1);
         chk($sformatf("b3_pins%0d", k), 32'(pins3), select_in ? 32'b111111 : 32'b110011);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
